cpu_control: RTL and testbench
==============================

# cpu_control

Fetch/decode stage of the simple 8-bit processor. Holds the program counter, decodes each 32-bit instruction into register-file addresses, an immediate, operand-mux selects and the 3-bit ALU operation, and resolves `j`/`beq` using the ALU zero flag. It sits directly upstream of the ALU and register file, and downstream of instruction memory. Instruction memory may stall it through a busywait handshake.

## Interface
- No parameters. Fixed: 32-bit PC and instruction, 8-bit data, 8 registers.
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  reset; synchronous and active-high.
- INSTRUCTION  in  32  fields: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm.
- INSTR_BUSYWAIT  in  1  instruction memory not ready; INSTRUCTION is invalid this cycle.
- ALU_ZERO  in  1  ALU ZERO output for the current instruction.
- PC  out  32  current fetch address.
- READREG1, READREG2, WRITEREG  out  3  register addresses taken from bits [10:8], [2:0] and [18:16].
- IMMEDIATE  out  8  INSTRUCTION[7:0].
- IMM_SEL  out  1  when 1, ALU DATA2 takes IMMEDIATE; when 0, it takes the register.
- NEG_SEL  out  1  when 1, DATA2 is two's-complemented before the ALU.
- ALU_SELECT  out  3  operation code for the ALU SELECT input.
- WRITE_ENABLE  out  1  register-file write strobe for this cycle.
- HALTED  out  1  sticky flag for an illegal opcode.

## Operation
- Opcodes are decoded as follows. ALU_SELECT 000 means pass DATA2; 001 means add.
  - 0x00 loadi: ALU_SELECT 000, IMM_SEL 1, WRITE_ENABLE 1.
  - 0x01 mov: ALU_SELECT 000, WRITE_ENABLE 1.
  - 0x02 add: ALU_SELECT 001, WRITE_ENABLE 1.
  - 0x03 sub: ALU_SELECT 001, NEG_SEL 1, WRITE_ENABLE 1.
  - 0x04 and: ALU_SELECT 010, WRITE_ENABLE 1.
  - 0x05 or: ALU_SELECT 011, WRITE_ENABLE 1.
  - 0x06 j: ALU_SELECT 000, no write.
  - 0x07 beq: ALU_SELECT 001, NEG_SEL 1, no write.
  - Any select not listed above is 0.
- Opcodes 0x08–0xFF are illegal.
- FSM states and transitions:
  - RUN is the normal state.
  - RUN goes to STALL when INSTR_BUSYWAIT=1. STALL returns to RUN when INSTR_BUSYWAIT=0.
  - RUN goes to HALT when a valid illegal opcode is decoded.
  - HALT is left only by RESET.
  - RESET from any state goes to RUN.
- Next-PC rules:
  - Base value is PC+4.
  - For `j`, and for `beq` with ALU_ZERO=1: PC+4 + (sext8→32(INSTRUCTION[23:16]) << 2).
  - All PC arithmetic is modulo 2^32; wrap-around is legal and silent.
- Gating:
  - WRITE_ENABLE is forced to 0 in STALL, in HALT, and while RESET=1.
  - The PC holds in STALL and in HALT.
  - Decode outputs other than WRITE_ENABLE stay combinational in every state.
- Simultaneous events:
  - RESET beats everything else.
  - INSTR_BUSYWAIT beats an illegal opcode: the instruction is not valid, so the block does not halt.
  - ALU_ZERO is ignored for every opcode except `beq`.

## Timing
- Reset values, applied at the first rising edge with RESET=1: PC=0, state RUN, HALTED=0. WRITE_ENABLE=0 for as long as RESET is high.
- Decode is combinational from INSTRUCTION, with zero cycles of latency. The ALU result and ALU_ZERO must settle within the same cycle.
- The PC updates once per rising edge when not stalled or halted, giving one instruction per cycle.
- Branch resolution: `beq`/`j` take effect on the edge that ends the instruction's cycle. There are no delay slots.
- Busywait handshake:
  - INSTR_BUSYWAIT is sampled at the rising edge; while it is 1, the PC holds.
  - The instruction present on the first edge with INSTR_BUSYWAIT=0 executes.
- RESET asserted mid-stall or during HALT restarts at PC=0 on that edge.
- HALTED rises on the edge that latches the illegal opcode.
- Unit `#` delays are optional and not functional. Correctness must not depend on them.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants `OP_LOADI`..`OP_BEQ`;
  - ALU select constants `ALU_FWD`, `ALU_ADD`, `ALU_AND`, `ALU_OR`;
  - the FSM state encoding (RUN, STALL, HALT).
- One sub-module, `pc_unit`, contains:
  - the PC register with synchronous reset;
  - the hold enable;
  - the PC+4 adder;
  - the sign-extend/shift branch-target adder;
  - the next-PC mux, driven by a `take_branch` input.
- `cpu_control` holds the decoder and the FSM.

## Test plan
- **Reset:** hold RESET=1 for 2 cycles with arbitrary INSTRUCTION → PC=0, WRITE_ENABLE=0, HALTED=0. After release with busywait low → PC reads 0x0, 0x4, 0x8.
- **Decode:** INSTRUCTION 0x02030102 → ALU_SELECT=001, NEG_SEL=0, IMM_SEL=0, WRITEREG=3, READREG1=1, READREG2=2, WRITE_ENABLE=1. Then 0x000400F5 → IMM_SEL=1, IMMEDIATE=0xF5, ALU_SELECT=000.
- **Jump:** at PC=0x10, INSTRUCTION 0x06FE0000 → next PC=0x0C. At PC=0xFFFFFFFC, INSTRUCTION 0x06000000 → next PC=0x0 (wrap).
- **Beq:** at PC=0x20, INSTRUCTION 0x07020102.
  - With ALU_ZERO=1 → next PC=0x2C, WRITE_ENABLE=0.
  - Repeat with ALU_ZERO=0 → next PC=0x24.
- **Stall, then halt:** INSTR_BUSYWAIT=1 for 3 cycles with an `add` on the bus → PC held, WRITE_ENABLE=0. Illegal 0x09 presented while busy → no halt. After release, 0x09 → HALTED=1 and PC frozen for 5 cycles. RESET → PC=0, HALTED=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, ALU select and FSM definitions for the fetch/decode stage
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] alu_select;
        logic       imm_sel;
        logic       neg_sel;
        logic       write;
        logic       legal;
    } decode_t;

    // Unlisted opcodes fall through to all-zero controls with legal cleared.
    function automatic decode_t decode_op(input logic [7:0] op);
        decode_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            OP_LOADI: begin d.alu_select = ALU_FWD; d.imm_sel = 1'b1; d.write = 1'b1; end
            OP_MOV:   begin d.alu_select = ALU_FWD; d.write = 1'b1; end
            OP_ADD:   begin d.alu_select = ALU_ADD; d.write = 1'b1; end
            OP_SUB:   begin d.alu_select = ALU_ADD; d.neg_sel = 1'b1; d.write = 1'b1; end
            OP_AND:   begin d.alu_select = ALU_AND; d.write = 1'b1; end
            OP_OR:    begin d.alu_select = ALU_OR;  d.write = 1'b1; end
            OP_J:     begin d.alu_select = ALU_FWD; end
            OP_BEQ:   begin d.alu_select = ALU_ADD; d.neg_sel = 1'b1; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register with PC+4 and branch-target next-PC selection
module pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        take_branch,
    input  logic [7:0]  offset,
    output logic [31:0] pc
);

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Offset counts words relative to the following instruction; arithmetic wraps mod 2^32.
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
    assign next_pc  = take_branch ? target : pc_plus4;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else if (!hold) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - instruction decoder and run/stall/halt FSM of the 8-bit processor
module cpu_control
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_BUSYWAIT,
    input  logic        ALU_ZERO,
    output logic [31:0] PC,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic [2:0]  ALU_SELECT,
    output logic        WRITE_ENABLE,
    output logic        HALTED
);

    state_t      state;
    decode_t     dec;
    logic [7:0]  opcode;
    logic        valid;
    logic        take_branch;
    logic        unused_bits;

    assign opcode      = INSTRUCTION[31:24];
    assign dec         = decode_op(opcode);
    assign unused_bits = ^INSTRUCTION[15:11];

    assign READREG1   = INSTRUCTION[10:8];
    assign READREG2   = INSTRUCTION[2:0];
    assign WRITEREG   = INSTRUCTION[18:16];
    assign IMMEDIATE  = INSTRUCTION[7:0];
    assign IMM_SEL    = dec.imm_sel;
    assign NEG_SEL    = dec.neg_sel;
    assign ALU_SELECT = dec.alu_select;

    // An instruction executes only when memory has it ready and the core is not halted.
    assign valid        = !INSTR_BUSYWAIT && (state != ST_HALT);
    assign WRITE_ENABLE = dec.write && valid && !RESET;
    assign take_branch  = (opcode == OP_J) || ((opcode == OP_BEQ) && ALU_ZERO);

    pc_unit u_pc_unit (
        .clk         (CLK),
        .reset       (RESET),
        .hold        (!valid),
        .take_branch (take_branch),
        .offset      (INSTRUCTION[23:16]),
        .pc          (PC)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_RUN;
            HALTED <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_STALL: begin
                    if (INSTR_BUSYWAIT) begin
                        state <= ST_STALL;
                    end else if (!dec.legal) begin
                        state  <= ST_HALT;
                        HALTED <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - self-checking bench for cpu_control against a behavioural model
module tb_cpu_control;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_BUSYWAIT;
    logic        ALU_ZERO;
    logic [31:0] PC;
    logic [2:0]  READREG1, READREG2, WRITEREG;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, NEG_SEL;
    logic [2:0]  ALU_SELECT;
    logic        WRITE_ENABLE;
    logic        HALTED;

    int total = 0;
    int bad   = 0;

    // Expected controls for opcodes 0..7, straight from the opcode list.
    logic [2:0] sel_tab [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    logic       imm_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       neg_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       wr_tab  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    cpu_control dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .INSTRUCTION    (INSTRUCTION),
        .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
        .ALU_ZERO       (ALU_ZERO),
        .PC             (PC),
        .READREG1       (READREG1),
        .READREG2       (READREG2),
        .WRITEREG       (WRITEREG),
        .IMMEDIATE      (IMMEDIATE),
        .IMM_SEL        (IMM_SEL),
        .NEG_SEL        (NEG_SEL),
        .ALU_SELECT     (ALU_SELECT),
        .WRITE_ENABLE   (WRITE_ENABLE),
        .HALTED         (HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic [31:0] instr, input logic busy, input logic zero);
        INSTRUCTION    = instr;
        INSTR_BUSYWAIT = busy;
        ALU_ZERO       = zero;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive($urandom, 1'b0, 1'b0);
        tick();
        drive($urandom, 1'b0, 1'b1);
        total++;
        if (WRITE_ENABLE !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", WRITE_ENABLE); end
        tick();
        total++;
        if (PC !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", PC); end
        total++;
        if (HALTED !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", HALTED); end
        RESET = 1'b0;
        drive(32'h01000000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (PC !== 32'(i * 4)) begin bad++; $display("FAIL release_pc%0d got=%h want=%h", i, PC, i * 4); end
            tick();
        end
    endtask

    task automatic test_decode();
        drive(32'h02030102, 1'b0, 1'b0);
        total++;
        if ({ALU_SELECT, NEG_SEL, IMM_SEL, WRITEREG, READREG1, READREG2, WRITE_ENABLE} !==
            {3'b001, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 1'b1}) begin
            bad++;
            $display("FAIL decode_add got sel=%b neg=%b imm=%b wr=%0d r1=%0d r2=%0d we=%b",
                     ALU_SELECT, NEG_SEL, IMM_SEL, WRITEREG, READREG1, READREG2, WRITE_ENABLE);
        end
        tick();
        drive(32'h000400F5, 1'b0, 1'b0);
        total++;
        if ({IMM_SEL, IMMEDIATE, ALU_SELECT} !== {1'b1, 8'hF5, 3'b000}) begin
            bad++;
            $display("FAIL decode_loadi got imm_sel=%b imm=%h sel=%b want 1 f5 000", IMM_SEL, IMMEDIATE, ALU_SELECT);
        end
        tick();
    endtask

    task automatic test_jump();
        RESET = 1'b1; drive(32'h0, 1'b0, 1'b0); tick(); RESET = 1'b0;
        drive(32'h06030000, 1'b0, 1'b0); tick();
        total++;
        if (PC !== 32'h10) begin bad++; $display("FAIL jump_setup got=%h want=10", PC); end
        drive(32'h06FE0000, 1'b0, 1'b1); tick();
        total++;
        if (PC !== 32'h0C) begin bad++; $display("FAIL jump_back got=%h want=0c", PC); end
        drive(32'h06FB0000, 1'b0, 1'b0); tick();
        total++;
        if (PC !== 32'hFFFFFFFC) begin bad++; $display("FAIL jump_to_top got=%h want=fffffffc", PC); end
        drive(32'h06000000, 1'b0, 1'b0); tick();
        total++;
        if (PC !== 32'h0) begin bad++; $display("FAIL jump_wrap got=%h want=0", PC); end
    endtask

    task automatic test_beq();
        drive(32'h06070000, 1'b0, 1'b0); tick();
        drive(32'h07020102, 1'b0, 1'b1);
        total++;
        if (WRITE_ENABLE !== 1'b0 || NEG_SEL !== 1'b1 || ALU_SELECT !== 3'b001) begin
            bad++; $display("FAIL beq_decode got we=%b neg=%b sel=%b want 0 1 001", WRITE_ENABLE, NEG_SEL, ALU_SELECT);
        end
        tick();
        total++;
        if (PC !== 32'h2C) begin bad++; $display("FAIL beq_taken got=%h want=2c", PC); end
        drive(32'h06FC0000, 1'b0, 1'b0); tick();
        drive(32'h07020102, 1'b0, 1'b0); tick();
        total++;
        if (PC !== 32'h24) begin bad++; $display("FAIL beq_not_taken got=%h want=24", PC); end
    endtask

    task automatic test_stall_halt();
        RESET = 1'b1; drive(32'h0, 1'b0, 1'b0); tick(); RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h02030102, 1'b1, 1'b0);
            total++;
            if (WRITE_ENABLE !== 1'b0) begin bad++; $display("FAIL stall_we%0d got=%b want=0", i, WRITE_ENABLE); end
            tick();
            total++;
            if (PC !== 32'h0) begin bad++; $display("FAIL stall_pc%0d got=%h want=0", i, PC); end
        end
        drive(32'h09000000, 1'b1, 1'b0); tick();
        total++;
        if (HALTED !== 1'b0 || PC !== 32'h0) begin bad++; $display("FAIL busy_illegal got halted=%b pc=%h want 0 0", HALTED, PC); end
        drive(32'h09000000, 1'b0, 1'b0); tick();
        total++;
        if (HALTED !== 1'b1 || PC !== 32'h4) begin bad++; $display("FAIL halt_entry got halted=%b pc=%h want 1 4", HALTED, PC); end
        for (int i = 0; i < 5; i++) begin
            drive(32'h06100000, 1'b0, 1'b1);
            total++;
            if (WRITE_ENABLE !== 1'b0) begin bad++; $display("FAIL halt_we%0d got=%b want=0", i, WRITE_ENABLE); end
            tick();
            total++;
            if (PC !== 32'h4 || HALTED !== 1'b1) begin bad++; $display("FAIL halt_frozen%0d got pc=%h halted=%b want 4 1", i, PC, HALTED); end
        end
        RESET = 1'b1; drive(32'h02030102, 1'b0, 1'b0); tick();
        total++;
        if (PC !== 32'h0 || HALTED !== 1'b0) begin bad++; $display("FAIL halt_reset got pc=%h halted=%b want 0 0", PC, HALTED); end
        RESET = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] model_pc;
        logic [31:0] instr;
        logic [7:0]  op;
        logic        busy, zero, branch;
        int          errs;
        model_pc = 32'h0;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            busy = ($urandom_range(0, 3) == 0);
            zero = $urandom_range(0, 1) == 1;
            op   = busy && ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            instr = {op, 24'($urandom)};
            drive(instr, busy, zero);
            total++;
            if (op < 8) begin
                if ({ALU_SELECT, IMM_SEL, NEG_SEL, WRITE_ENABLE, READREG1, READREG2, WRITEREG, IMMEDIATE} !==
                    {sel_tab[op[2:0]], imm_tab[op[2:0]], neg_tab[op[2:0]], wr_tab[op[2:0]] && !busy,
                     instr[10:8], instr[2:0], instr[18:16], instr[7:0]}) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_decode n=%0d instr=%h busy=%b got sel=%b imm=%b neg=%b we=%b",
                                            n, instr, busy, ALU_SELECT, IMM_SEL, NEG_SEL, WRITE_ENABLE);
                end
            end else if (WRITE_ENABLE !== 1'b0) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_illegal_we n=%0d got=%b want=0", n, WRITE_ENABLE);
            end
            tick();
            if (!busy) begin
                branch = (op == 8'h06) || (op == 8'h07 && zero);
                model_pc = model_pc + 32'd4 + (branch ? 32'($signed(instr[23:16])) * 32'd4 : 32'd0);
            end
            total++;
            if (PC !== model_pc || HALTED !== 1'b0) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_pc n=%0d got=%h halted=%b want=%h 0", n, PC, HALTED, model_pc);
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        INSTRUCTION = 32'h0;
        INSTR_BUSYWAIT = 1'b0;
        ALU_ZERO = 1'b0;
        #1;
        test_reset();
        test_decode();
        test_jump();
        test_beq();
        test_stall_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
